// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - UART receive framer with output handshake and error flags
//
// Optional feature macro: UART_RX_FIFO_EN (4-entry output FIFO plus rx_level port).
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   rxd          asynchronous serial input, idle high
//   rx_data      received data, LSB received first
//   rx_type      0 = UART_COMMAND, 1 = UART_RESPONSE
//   rx_valid     frame available
//   rx_ready     consumer accepts the frame
//   parity_err   parity mismatch for the presented frame
//   frame_err    stop-bit failure for the presented frame
//   overrun      sticky, a completed frame was dropped
//   overrun_clr  clears overrun (a simultaneous set wins)
//   rx_level     FIFO occupancy (UART_RX_FIFO_EN only)
//   busy         FSM is not idle
module uart_rx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int TYPE_BIT     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_type,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 overrun_clr,
`ifdef UART_RX_FIFO_EN
  output logic [2:0]           rx_level,
`endif
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, TYPE, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t               state, state_n;
  logic                 sync1, rxs;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 type_r, par_r, ferr_r;
  logic                 done;
  logic                 tick, half_tick, last_data, last_stop;
  logic                 frame_perr;
  logic                 ovr_set;
  state_t               after_data, after_type;

  // Two-flop synchroniser; resets to the idle level so no false start follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign tick      = (cnt == CW'(CLKS_PER_BIT - 1));
  assign half_tick = (cnt == CW'(HALF - 1));
  assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    after_type = (PARITY_MODE != 0) ? PARITY : STOP;
    after_data = (TYPE_BIT != 0) ? TYPE : after_type;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (!rxs) state_n = START;
      START:     if (half_tick) state_n = rxs ? IDLE : DATA;
      DATA:      if (tick && last_data) state_n = after_data;
      TYPE:      if (tick) state_n = after_type;
      PARITY:    if (tick) state_n = STOP;
      // A low stop sample means a break may be in progress: hold off start
      // detection until the line has returned high.
      STOP:      if (tick && last_stop) state_n = (ferr_r || !rxs) ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (rxs) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Baud counter restarts on every state change so START counts to the bit
  // centre and each later state samples a full bit period after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (state == IDLE || state == WAIT_HIGH || state_n != state) begin
      cnt     <= '0;
      bit_cnt <= '0;
    end else if (tick) begin
      cnt     <= '0;
      bit_cnt <= bit_cnt + 4'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      type_r <= 1'b0;
      par_r  <= 1'b0;
      ferr_r <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == STOP) && tick && last_stop;
      case (state)
        START: if (state_n == DATA) begin
          type_r <= 1'b0;
          par_r  <= 1'b0;
          ferr_r <= 1'b0;
        end
        DATA:   if (tick) shreg <= {rxs, shreg[DATA_BITS-1:1]};
        TYPE:   if (tick) type_r <= rxs;
        PARITY: if (tick) par_r <= rxs;
        STOP:   if (tick && !rxs) ferr_r <= 1'b1;
        default: ;
      endcase
    end
  end

  // Expected parity bit is the XOR of data and type, inverted for odd mode.
  assign frame_perr = (PARITY_MODE != 0) &&
                      (par_r != ((^shreg) ^ type_r ^ (PARITY_MODE == 2)));

`ifdef UART_RX_FIFO_EN
  logic [DATA_BITS-1:0] f_data [4];
  logic [3:0]           f_type, f_perr, f_ferr;
  logic [1:0]           wr_ptr, rd_ptr;
  logic [2:0]           level;
  logic                 pop, push;

  assign pop     = (level != 3'd0) && rx_ready;
  assign push    = done && ((level != 3'd4) || pop);
  assign ovr_set = done && (level == 3'd4) && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) f_data[i] <= '0;
      f_type <= '0;
      f_perr <= '0;
      f_ferr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        f_data[wr_ptr] <= shreg;
        f_type[wr_ptr] <= type_r;
        f_perr[wr_ptr] <= frame_perr;
        f_ferr[wr_ptr] <= ferr_r;
        wr_ptr         <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      level <= level + 3'(push) - 3'(pop);
    end
  end

  assign rx_valid   = (level != 3'd0);
  assign rx_data    = f_data[rd_ptr];
  assign rx_type    = f_type[rd_ptr];
  assign parity_err = f_perr[rd_ptr];
  assign frame_err  = f_ferr[rd_ptr];
  assign rx_level   = level;
`else
  assign ovr_set = done && rx_valid && !rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_type    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_valid   <= 1'b0;
    end else if (done && !ovr_set) begin
      // Covers completion in the same cycle as acceptance: valid stays high.
      rx_data    <= shreg;
      rx_type    <= type_r;
      parity_err <= frame_perr;
      frame_err  <= ferr_r;
      rx_valid   <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (ovr_set)     overrun <= 1'b1;
    else if (overrun_clr) overrun <= 1'b0;
  end

endmodule
